// File: rtl/sdpram_stream_reader_if.sv
// Handshake and RAM-port bundle for the stream reader: burst control, async-read RAM port, and
// the valid/ready output stream. master is the reader side; slave is the environment side.
interface sdpram_stream_reader_if #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 8
);
   logic                 start;
   logic [ADDRWIDTH-1:0] start_addr;
   logic [ADDRWIDTH:0]   length;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [ADDRWIDTH-1:0] ram_addr;
   logic [DATAWIDTH-1:0] ram_data;
   logic [DATAWIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (
      input  start, start_addr, length, abort, ram_data, out_ready,
      output busy, done, ram_addr, out_data, out_valid, out_last
   );

   modport slave (
      output start, start_addr, length, abort, ram_data, out_ready,
      input  busy, done, ram_addr, out_data, out_valid, out_last
   );
endinterface

// File: rtl/sdpram_stream_reader.sv
// Streams a burst of words out of an async-read RAM; first word two cycles after start.
// One-entry output register holds under out_ready=0, so the RAM address stalls with it.
module sdpram_stream_reader #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   sdpram_stream_reader_if.master  bus
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [ADDRWIDTH:0]   remaining_q, remaining_d;
   logic [ADDRWIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATAWIDTH-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 load;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      ram_addr_d  = ram_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      accept      = out_valid_q && bus.out_ready;
      load        = (state_q == RUN) && (remaining_q != '0) && (!out_valid_q || bus.out_ready);

      // abort wins over everything except reset, and never produces done
      if (bus.abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         remaining_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.length != '0) begin
                     ram_addr_d  = bus.start_addr;
                     remaining_d = bus.length;
                     state_d     = RUN;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (load) begin
                  out_data_d  = bus.ram_data;
                  out_valid_d = 1'b1;
                  out_last_d  = (remaining_q == (ADDRWIDTH+1)'(1));
                  ram_addr_d  = ram_addr_q + ADDRWIDTH'(1);
                  remaining_d = remaining_q - (ADDRWIDTH+1)'(1);
                  if (remaining_q == (ADDRWIDTH+1)'(1)) begin
                     state_d = FLUSH;
                  end
               end else if (accept) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
            end
            FLUSH: begin
               if (accept) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         ram_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         ram_addr_q  <= ram_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Randomized bench for the stream reader: each start pushes the expected word sequence
// (RAM contents at start+i, last flag on the final one) into a queue that a negedge monitor drains.
module tb_sdpram_stream_reader;
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } exp_t;

   logic clock;
   logic reset;
   logic [7:0] ram [256];

   sdpram_stream_reader_if #(.DATAWIDTH(8), .ADDRWIDTH(8)) bus ();

   sdpram_stream_reader #(.DATAWIDTH(8), .ADDRWIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   assign bus.ram_data = ram[bus.ram_addr];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int   n_vec;
   int   n_err;
   exp_t exp_q[$];
   logic ready_pat[$];
   logic rand_ready;
   logic zlen_exp;
   logic last_acc_q;
   logic stall_q;
   logic [7:0] held_data;
   logic held_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: done timing, stall hold, and word-by-word scoreboard compare
   always @(negedge clock) begin
      if (reset) begin
         last_acc_q = 1'b0;
         stall_q    = 1'b0;
         zlen_exp   = 1'b0;
      end else begin
         chk("done", 32'(bus.done), 32'(last_acc_q || zlen_exp));
         zlen_exp = 1'b0;
         if (stall_q) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(held_data));
            chk("hold_last", 32'(bus.out_last), 32'(held_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_word: got %0h expected no word at %0t", bus.out_data, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("word_data", 32'(bus.out_data), 32'(e.data));
               chk("word_last", 32'(bus.out_last), 32'(e.last));
            end
         end
         last_acc_q = bus.out_valid && bus.out_ready && bus.out_last && !bus.abort;
         stall_q    = bus.out_valid && !bus.out_ready && !bus.abort;
         held_data  = bus.out_data;
         held_last  = bus.out_last;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (ready_pat.size() > 0) bus.out_ready = ready_pat.pop_front();
      else bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   // returns one cycle after the start was presented (cycle N+1)
   task automatic start_burst(input logic [7:0] sa, input logic [8:0] len);
      bus.start      = 1'b1;
      bus.start_addr = sa;
      bus.length     = len;
      for (int i = 0; i < int'(len); i++) begin
         exp_t e;
         e.data = ram[8'(int'(sa) + i)];
         e.last = (i == int'(len) - 1);
         exp_q.push_back(e);
      end
      tick();
      bus.start = 1'b0;
      if (len == 9'd0) zlen_exp = 1'b1;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      for (k = 0; k < bound; k++) begin
         if (!bus.busy && !bus.out_valid && exp_q.size() == 0 && !zlen_exp) break;
         tick();
      end
      chk("burst_timeout", 32'(k >= bound), 32'd0);
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
      chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
      chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rand_ready = 1'b0;
      zlen_exp = 1'b0;
      last_acc_q = 1'b0;
      stall_q = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      bus.start = 1'b0;
      bus.start_addr = '0;
      bus.length = '0;
      bus.abort = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i);
      reset = 1'b1;
      tick();
      tick();
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // basic burst plus first-word latency
      start_burst(8'h10, 9'd4);
      chk("lat_addr", 32'(bus.ram_addr), 32'h10);
      chk("lat_busy", 32'(bus.busy), 32'd1);
      chk("lat_valid_n1", 32'(bus.out_valid), 32'd0);
      tick();
      chk("lat_valid_n2", 32'(bus.out_valid), 32'd1);
      chk("lat_data_n2", 32'(bus.out_data), 32'h10);
      wait_idle(50);

      // address wrap
      start_burst(8'hFE, 9'd4);
      wait_idle(50);

      // stall pattern 1,0,0,1 while words are flowing
      ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      start_burst(8'h20, 9'd6);
      wait_idle(50);

      // abort after the second word, then restart immediately
      start_burst(8'h30, 9'd8);
      tick();
      tick();
      bus.abort = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.abort = 1'b1;
      tick();
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      bus.abort = 1'b0;
      exp_q.delete();
      start_burst(8'h40, 9'd3);
      chk("restart_busy", 32'(bus.busy), 32'd1);
      wait_idle(50);

      // zero length, then full-depth burst under random backpressure
      start_burst(8'h00, 9'd0);
      chk("zlen_busy", 32'(bus.busy), 32'd0);
      wait_idle(10);
      rand_ready = 1'b1;
      start_burst(8'h80, 9'd256);
      wait_idle(2000);

      // reset mid-burst together with a start
      rand_ready = 1'b0;
      start_burst(8'h50, 9'd8);
      tick();
      tick();
      reset = 1'b1;
      bus.start = 1'b1;
      bus.start_addr = 8'h99;
      bus.length = 9'd5;
      bus.out_ready = 1'b0;
      tick();
      chk_reset_outputs("midreset");
      reset = 1'b0;
      bus.start = 1'b0;
      exp_q.delete();
      tick();
      chk("post_reset_busy", 32'(bus.busy), 32'd0);
      chk("post_reset_valid", 32'(bus.out_valid), 32'd0);

      // random bursts over random RAM contents
      rand_ready = 1'b1;
      for (int b = 0; b < 25; b++) begin
         logic [8:0] len;
         for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
         len = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 2)) : 9'($urandom_range(1, 40));
         start_burst(8'($urandom_range(0, 255)), len);
         wait_idle(400);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sdpram_stream_reader.md
SDPRAM_STREAM_READER -- requirements
Module: sdpram_stream_reader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, width of one RAM word and of the stream data.
REQ-002 SHALL have parameter ADDRWIDTH, default 8, RAM address width; the RAM depth is 2**ADDRWIDTH.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port start_addr, input, ADDRWIDTH, first RAM address of the burst.
REQ-007 SHALL have port length, input, ADDRWIDTH+1, word count of the burst, 0..2**ADDRWIDTH.
REQ-008 SHALL have port abort, input, 1, cancels the burst in progress.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a burst completes normally.
REQ-011 SHALL have port ram_addr, output, ADDRWIDTH, registered read address driven to the RAM's asynchronous read port.
REQ-012 SHALL have port ram_data, input, DATAWIDTH, combinational RAM read data for ram_addr in the same cycle.
REQ-013 SHALL have port out_data, output, DATAWIDTH, registered stream data.
REQ-014 SHALL have port out_valid, output, 1, out_data holds a word.
REQ-015 SHALL have port out_ready, input, 1, sink accepts the word when out_valid and out_ready are both high.
REQ-016 SHALL have port out_last, output, 1, qualifies the final word of the burst.

Function
REQ-017 SHALL implement states IDLE, RUN and FLUSH.
REQ-018 In IDLE, start=1 with length>0 SHALL load ram_addr<=start_addr and remaining<=length, then enter RUN.
REQ-019 In IDLE, start=1 with length=0 SHALL pulse done on the next cycle, emit no word and remain in IDLE.
REQ-020 A start received outside IDLE SHALL be ignored.
REQ-021 A load SHALL occur in RUN when remaining!=0 and (out_valid=0 or out_ready=1).
REQ-022 On a load: out_data<=ram_data, out_valid<=1, out_last<=(remaining==1), ram_addr<=ram_addr+1 modulo 2**ADDRWIDTH, remaining<=remaining-1.
REQ-023 Throughput SHALL be one word per cycle while out_ready stays high.
REQ-024 Latency SHALL be: start accepted at cycle N, ram_addr=start_addr at N+1, first out_valid at N+2.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and ram_addr SHALL hold.
REQ-026 An accept without a simultaneous load SHALL clear out_valid and out_last.
REQ-027 When remaining reaches 0, the block SHALL go to FLUSH; the transition to IDLE with a done pulse SHALL occur in the cycle in which the out_last word is accepted.
REQ-028 The address SHALL wrap from 2**ADDRWIDTH-1 to 0 within a burst; length=2**ADDRWIDTH SHALL read every word exactly once.
REQ-029 abort=1 in RUN or FLUSH SHALL, on the next cycle, set out_valid=0, out_last=0, state IDLE, and produce no done pulse.
REQ-030 abort SHALL take priority over start and over a load; abort in IDLE SHALL have no effect.
REQ-031 Each emitted word SHALL equal ram_data at its load cycle; concurrent RAM writes to later addresses SHALL become visible when those addresses are read.

Reset
REQ-032 reset=1 SHALL force IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_addr=0, remaining=0.
REQ-033 reset SHALL override start, abort and loads in the same cycle; a burst in progress SHALL be dropped with no done pulse.

Verification
REQ-034 Stimulus: RAM[i]=i, start_addr=0x10, length=4, out_ready=1. Required: out_data 10,11,12,13 on consecutive cycles, out_last on 13, done one cycle after 13 is accepted.
REQ-035 Stimulus: start_addr=0xFE, length=4, ADDRWIDTH=8. Required: reads at addresses FE,FF,00,01 in that order.
REQ-036 Stimulus: out_ready toggled 1,0,0,1 during a burst. Required: out_data held stable while stalled; no word lost or duplicated.
REQ-037 Stimulus: abort asserted after the 2nd word of a length=8 burst. Required: out_valid=0 on the next cycle, busy=0, no done pulse, and a new start is accepted on the following cycle.
REQ-038 Stimulus: length=0 start; then length=256 start. Required: a done pulse with no words for the first; 256 words followed by a single done for the second.
REQ-039 Stimulus: reset asserted mid-burst together with start. Required: all outputs at their reset values on the next cycle and the start is ignored.
